branch_exec_unit: RTL and testbench

- Branch/jump execution stage directly downstream of the branch/jump reservation station; consumes the 112-bit issue bundle {inst_type[9:0], dest[5:0], opr1[31:0], opr2[31:0], addr[31:0]} qualified by ex_en.
- Resolves the branch condition and computes the target.
- Emits a registered redirect on a taken branch or jump (static predict-not-taken front end).
- Queues completion results and places them on a common data bus slot ({tag[5:0], data[31:0]}) under request/grant arbitration.

---
 rtl/branch_exec_unit.sv | 159 +++++++++++++++
 tb/tb_branch_exec_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_exec_unit.sv
// Branch/jump execution stage: resolves conditions, emits registered redirects and
// queues completion results for the common data bus under request/grant arbitration.
module branch_exec_unit #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ex_en,
  input  logic [111:0] rs2exe,
  input  logic         kill_in,
  input  logic         cdb_grant,
  output logic         cdb_req,
  output logic [37:0]  cdb_out,
  output logic         redirect_valid,
  output logic [31:0]  redirect_pc,
  output logic         stall,
  output logic         overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [3:0] {
    OP_BEQ  = 4'd0,
    OP_BNE  = 4'd1,
    OP_BLT  = 4'd2,
    OP_BGE  = 4'd3,
    OP_BLTU = 4'd4,
    OP_BGEU = 4'd5,
    OP_JAL  = 4'd6,
    OP_JALR = 4'd7
  } op_e;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] data;
    logic        protect;
  } entry_t;

  // E1 pipeline register: only the fields this unit actually decodes.
  logic        e1_valid;
  logic [3:0]  e1_op;
  logic [5:0]  e1_dest;
  logic [31:0] e1_opr1;
  logic [31:0] e1_opr2;
  logic [31:0] e1_addr;

  // Upper inst_type bits carry no meaning for branch resolution.
  logic unused_inst_bits;
  assign unused_inst_bits = ^rs2exe[111:106];

  // Result queue: slot 0 is always the head, so compaction on kill is a simple re-pack.
  entry_t        q     [DEPTH];
  entry_t        q_nxt [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          overflow_set;

  logic        taken;
  logic [31:0] target;
  logic [31:0] result;
  logic        pop;
  logic        push;

  // E2: condition resolution and target/link selection.
  always_comb begin
    taken  = 1'b0;
    target = e1_addr;
    result = '0;
    case (op_e'(e1_op))
      OP_BEQ:  taken = (e1_opr1 == e1_opr2);
      OP_BNE:  taken = (e1_opr1 != e1_opr2);
      OP_BLT:  taken = ($signed(e1_opr1) <  $signed(e1_opr2));
      OP_BGE:  taken = ($signed(e1_opr1) >= $signed(e1_opr2));
      OP_BLTU: taken = (e1_opr1 <  e1_opr2);
      OP_BGEU: taken = (e1_opr1 >= e1_opr2);
      OP_JAL: begin
        taken  = 1'b1;
        result = e1_opr1;
      end
      OP_JALR: begin
        taken  = 1'b1;
        target = (e1_opr1 + e1_addr) & 32'hFFFF_FFFE;
        result = e1_opr2;
      end
      default: ;
    endcase
    if (e1_op < 4'd6)
      result = {31'b0, taken};
  end

  assign pop  = cdb_req && cdb_grant;
  assign push = e1_valid && !kill_in;

  // Next queue image: drop the popped head, drop unprotected entries on kill,
  // re-pack survivors toward slot 0, then append the E2 result if there is room.
  // NOTE: every variable written here gets a default before any conditional update;
  // count_nxt is a blocking running index, which is correct inside combinational logic.
  always_comb begin
    q_nxt        = '{default: '0};
    count_nxt    = '0;
    overflow_set = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && !(pop && i == 0) && (!kill_in || q[i].protect)) begin
        q_nxt[count_nxt[AW-1:0]] = q[i];
        if (kill_in)
          q_nxt[count_nxt[AW-1:0]].protect = 1'b0;
        count_nxt = count_nxt + CW'(1);
      end
    end
    if (push) begin
      if (count_nxt < CW'(DEPTH)) begin
        q_nxt[count_nxt[AW-1:0]] = '{tag: e1_dest, data: result, protect: taken};
        count_nxt = count_nxt + CW'(1);
      end else begin
        overflow_set = 1'b1;
      end
    end
  end

  // NOTE: the queue storage is reset because its head drives cdb_out directly and
  // must read zero after reset; it is only DEPTH entries, so this is cheap.
  always_ff @(posedge clk) begin
    if (reset) begin
      e1_valid       <= 1'b0;
      count          <= '0;
      q              <= '{default: '0};
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      overflow       <= 1'b0;
    end else begin
      e1_valid       <= ex_en && !kill_in;
      count          <= count_nxt;
      q              <= q_nxt;
      redirect_valid <= push && taken;
      if (push && taken)
        redirect_pc <= target;
      if (overflow_set)
        overflow <= 1'b1;
    end
  end

  // Operand capture needs no reset: it is only consumed while e1_valid is set.
  always_ff @(posedge clk) begin
    if (ex_en && !kill_in) begin
      e1_op   <= rs2exe[105:102];
      e1_dest <= rs2exe[101:96];
      e1_opr1 <= rs2exe[95:64];
      e1_opr2 <= rs2exe[63:32];
      e1_addr <= rs2exe[31:0];
    end
  end

  assign cdb_req = (count != '0);
  assign cdb_out = {q[0].tag, q[0].data};
  // One slot of slack is kept for the result still sitting in E1.
  assign stall   = (({1'b0, count} + (CW+1)'(e1_valid)) >= (CW+1)'(DEPTH - 1));

endmodule

// File: tb/tb_branch_exec_unit.sv
// Self-checking bench for branch_exec_unit: transaction-level reference model feeds
// scoreboard queues that a separate negedge monitor drains and compares.
module tb_branch_exec_unit;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         ex_en;
  logic [111:0] rs2exe;
  logic         kill_in;
  logic         cdb_grant;
  logic         cdb_req;
  logic [37:0]  cdb_out;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         stall;
  logic         overflow;

  always #5 clk = ~clk;

  branch_exec_unit #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_en          (ex_en),
    .rs2exe         (rs2exe),
    .kill_in        (kill_in),
    .cdb_grant      (cdb_grant),
    .cdb_req        (cdb_req),
    .cdb_out        (cdb_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .overflow       (overflow)
  );

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] data;
    bit          prot;
  } ent_t;

  // Scoreboard: expected queue contents and expected redirect pulses.
  ent_t        sb[$];
  logic [31:0] rq[$];
  bit          pend_v;
  ent_t        pend_e;
  bit          pend_taken;
  logic [31:0] pend_tgt;
  bit          ovf_exp;
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          pop_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of one issue bundle.
  function automatic void ref_exec(input logic [111:0] b, output ent_t e,
                                   output bit taken, output logic [31:0] tgt);
    logic [3:0]  op;
    logic [31:0] a, c, ad;
    op = b[105:102];
    a  = b[95:64];
    c  = b[63:32];
    ad = b[31:0];
    taken  = 1'b0;
    tgt    = ad;
    e.tag  = b[101:96];
    e.data = '0;
    case (op)
      4'd0: taken = (a == c);
      4'd1: taken = (a != c);
      4'd2: taken = ($signed(a) < $signed(c));
      4'd3: taken = ($signed(a) >= $signed(c));
      4'd4: taken = (a < c);
      4'd5: taken = (a >= c);
      4'd6: begin taken = 1'b1; e.data = a; end
      4'd7: begin taken = 1'b1; tgt = (a + ad) & ~32'h1; e.data = c; end
      default: ;
    endcase
    if (op <= 4'd5) e.data = taken ? 32'd1 : 32'd0;
    e.prot = taken;
  endfunction

  // Advance the model by one clock edge using the inputs that were just sampled.
  function automatic void model_edge();
    ent_t        e;
    bit          t;
    logic [31:0] g;
    ent_t        keep[$];
    if (reset) begin
      sb.delete(); rq.delete(); pend_v = 1'b0; ovf_exp = 1'b0;
      return;
    end
    if (kill_in) begin
      foreach (sb[i]) if (sb[i].prot) begin e = sb[i]; e.prot = 1'b0; keep.push_back(e); end
      sb = keep;
      pend_v = 1'b0;
      return;
    end
    if (pend_v) begin
      if (sb.size() >= DEPTH) ovf_exp = 1'b1;
      else sb.push_back(pend_e);
      if (pend_taken) rq.push_back(pend_tgt);
    end
    pend_v = ex_en;
    if (ex_en) begin
      ref_exec(rs2exe, e, t, g);
      pend_e = e; pend_taken = t; pend_tgt = g;
    end
  endfunction

  function automatic logic [111:0] mk(input logic [3:0] op, input logic [5:0] d,
                                      input logic [31:0] a, input logic [31:0] c,
                                      input logic [31:0] ad);
    return {6'($urandom), op, d, a, c, ad};
  endfunction

  function automatic logic [31:0] rand_opr();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [111:0] rand_bundle();
    logic [31:0] a, c;
    a = rand_opr();
    c = ($urandom_range(0, 3) == 0) ? a : rand_opr();
    return mk(4'($urandom_range(0, 11)), 6'($urandom), a, c, $urandom);
  endfunction

  // One clock cycle: drive, take the edge, update the model, settle past the edge.
  task automatic cycle(input bit en, input logic [111:0] b, input bit k, input bit g);
    ex_en = en; rs2exe = b; kill_in = k; cdb_grant = g;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: compares at mid-cycle whenever the DUT presents a result or redirect.
  always @(negedge clk) begin
    ent_t        e;
    logic [31:0] r;
    bit          exp_stall;
    if (mon_en) begin
      exp_stall = (sb.size() + int'(pend_v)) >= DEPTH - 1;
      check("stall", stall, exp_stall);
      check("cdb_req", cdb_req, sb.size() != 0);
      check("overflow", overflow, ovf_exp);
      check("redirect_valid", redirect_valid, rq.size() != 0);
      if (cdb_grant && sb.size() != 0) begin
        e = sb.pop_front();
        check("cdb_out", cdb_out, {e.tag, e.data});
        pop_cnt++;
      end
      if (rq.size() != 0) begin
        r = rq.pop_front();
        if (redirect_valid) check("redirect_pc", redirect_pc, r);
      end
    end
  end

  initial begin
    bit cur, prev_stall, en;
    int issued, p0;

    reset = 1'b1; ex_en = 1'b0; rs2exe = '0; kill_in = 1'b0; cdb_grant = 1'b0;
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    mon_en = 1'b1;
    check("rst_cdb_out", cdb_out, 38'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    reset = 1'b0;

    // BEQ taken, grant held high: redirect and result both in cycle 2.
    cycle(1, mk(4'd0, 6'd3, 32'd5, 32'd5, 32'h100), 0, 1);
    cycle(0, '0, 0, 1);
    check("beq_rv", redirect_valid, 1);
    check("beq_pc", redirect_pc, 32'h100);
    check("beq_cdb", cdb_out, {6'd3, 32'd1});
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);

    // Signed vs unsigned less-than on the same operands.
    cycle(1, mk(4'd2, 6'd4, 32'hFFFF_FFFF, 32'd1, 32'h200), 0, 1);
    cycle(1, mk(4'd4, 6'd5, 32'hFFFF_FFFF, 32'd1, 32'h300), 0, 1);
    check("blt_pc", redirect_pc, 32'h200);
    check("blt_cdb", cdb_out, {6'd4, 32'd1});
    cycle(0, '0, 0, 1);
    check("bltu_rv", redirect_valid, 0);
    check("bltu_cdb", cdb_out, {6'd5, 32'd0});
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);

    // JALR target clears bit 0; link comes from opr2.
    cycle(1, mk(4'd7, 6'd7, 32'h1003, 32'h2004, 32'h10), 0, 1);
    cycle(0, '0, 0, 1);
    check("jalr_pc", redirect_pc, 32'h1012);
    check("jalr_cdb", cdb_out, {6'd7, 32'h2004});
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);

    // Backpressure: issue while honouring last cycle's stall, no grant.
    issued = 0; prev_stall = 1'b0;
    for (int c = 0; c < 12; c++) begin
      en  = (issued < 4) && !prev_stall;
      cur = stall;
      cycle(en, rand_bundle(), 0, 0);
      if (en) issued++;
      prev_stall = cur;
    end
    check("bp_issued", issued, 4);
    check("bp_stall", stall, 1);
    check("bp_ovf", overflow, 0);
    p0 = pop_cnt;
    repeat (4) cycle(0, '0, 0, 1);
    check("bp_drained", pop_cnt - p0, 4);
    check("bp_empty", cdb_req, 0);

    // Kill: unprotected BNE removed, taken JAL survives, concurrent issue dropped.
    cycle(1, mk(4'd1, 6'd10, 32'd9, 32'd9, 32'h400), 0, 0);
    cycle(1, mk(4'd6, 6'd11, 32'h504, 32'd0, 32'h500), 0, 0);
    cycle(0, '0, 0, 0);
    cycle(1, rand_bundle(), 1, 0);
    check("kill_req", cdb_req, 1);
    check("kill_head", cdb_out, {6'd11, 32'h504});
    check("kill_rv", redirect_valid, 0);
    p0 = pop_cnt;
    cycle(0, '0, 0, 1);
    check("kill_one_left", pop_cnt - p0, 1);
    check("kill_empty", cdb_req, 0);
    cycle(0, '0, 0, 1);
    check("kill_no_late", cdb_req, 0);

    // Kill with a taken jump still in E1: no redirect, no result.
    cycle(1, mk(4'd6, 6'd12, 32'h604, 32'd0, 32'h600), 0, 1);
    cycle(0, '0, 1, 1);
    check("kill_e1_rv", redirect_valid, 0);
    check("kill_e1_req", cdb_req, 0);
    cycle(0, '0, 0, 1);

    // Overflow: five forced issues into a four-entry queue.
    repeat (5) cycle(1, rand_bundle(), 0, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    check("ovf_set", overflow, 1);
    p0 = pop_cnt;
    repeat (5) cycle(0, '0, 0, 1);
    check("ovf_count4", pop_cnt - p0, 4);

    // Reset mid-stream with a jump redirect in flight.
    cycle(1, mk(4'd6, 6'd20, 32'h44, 32'd0, 32'h40), 0, 0);
    cycle(1, rand_bundle(), 0, 0);
    reset = 1'b1;
    cycle(1, mk(4'd6, 6'd21, 32'h88, 32'd0, 32'h80), 0, 1);
    check("mrst_req", cdb_req, 0);
    check("mrst_cdb", cdb_out, 38'h0);
    check("mrst_rv", redirect_valid, 0);
    check("mrst_pc", redirect_pc, 32'h0);
    check("mrst_stall", stall, 0);
    check("mrst_ovf", overflow, 0);
    reset = 1'b0;

    // Randomised traffic with occasional kills and bursty grants.
    prev_stall = 1'b0;
    for (int c = 0; c < 400; c++) begin
      en  = !prev_stall && ($urandom_range(0, 3) != 0);
      cur = stall;
      cycle(en, rand_bundle(), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      prev_stall = cur;
    end
    repeat (8) cycle(0, '0, 0, 1);
    check("final_empty", cdb_req, 0);
    check("final_ovf", overflow, 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
